// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Brief    : Stall-request, exception and stall/flush bundle between the core
//            pipeline and the pipe_ctrl sequencing controller.
// Revision : 1.0
// ============================================================================
interface pipe_ctrl_if;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout_o;
    logic [31:0] stall_cnt_o;

    // Pipeline side
    modport master (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, stall_timeout_o, stall_cnt_o
    );

    // Controller side
    modport slave (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, stall_timeout_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Stall/flush sequencing for the 5-stage core with exception
//            freeze/flush FSM, stall watchdog and stall-cycle counter.
// Revision : 1.0
// ============================================================================
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam logic [31:0] c_ERET_CODE = 32'h0000_000e;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FREEZE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [5:0]  w_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            flush_q     <= 1'b0;
            new_pc_q    <= 32'h0;
            wd_cnt_q    <= 16'h0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            new_pc_q    <= new_pc_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Exception beats every stall request; the excepting instruction is held in MEM.
    always_comb begin
        state_d  = state_q;
        new_pc_d = new_pc_q;
        w_stall  = 6'b000000;
        case (state_q)
            S_RUN: begin
                if (bus.excepttype_i != 32'h0) begin
                    w_stall  = 6'b111111;
                    state_d  = S_FREEZE;
                    new_pc_d = (bus.excepttype_i == c_ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
                end else if (bus.stallreq_from_mem) begin
                    w_stall = 6'b011111;
                end else if (bus.stallreq_from_ex) begin
                    w_stall = 6'b001111;
                end else if (bus.stallreq_from_id) begin
                    w_stall = 6'b000111;
                end else if (bus.stallreq_from_if) begin
                    w_stall = 6'b000011;
                end
            end
            S_FREEZE: begin
                w_stall = 6'b111111;
                state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign flush_d = (state_d == S_FLUSH);

    // Watchdog only advances on RUN-state stalls; FREEZE holds the count.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (w_stall == 6'b000000) begin
            wd_cnt_d = 16'h0;
        end else if ((state_q == S_RUN) && (wd_cnt_q < STALL_TIMEOUT)) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
            if (wd_cnt_d == STALL_TIMEOUT) begin
                timeout_d = 1'b1;
            end
        end
    end

    assign stall_cnt_d = stall_cnt_q + {31'd0, w_stall[0]};

    assign bus.stall           = rst ? w_stall : 6'b000000;
    assign bus.flush           = flush_q;
    assign bus.new_pc          = new_pc_q;
    assign bus.stall_timeout_o = timeout_q;
    assign bus.stall_cnt_o     = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Self-checking bench for pipe_ctrl: vector table, corner-case
//            sequences and random stimulus against a timeline reference model.
// Revision : 1.0
// ============================================================================
module tb_pipe_ctrl;
    localparam logic [31:0] EXC_VEC = 32'h0000_0020;
    localparam logic [31:0] ERET    = 32'h0000_000e;
    localparam int          TO      = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .EXC_VECTOR    (EXC_VEC),
        .STALL_TIMEOUT (16'(TO))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc);
        bus.stallreq_from_mem = req[3];
        bus.stallreq_from_ex  = req[2];
        bus.stallreq_from_id  = req[1];
        bus.stallreq_from_if  = req[0];
        bus.excepttype_i      = exc;
        bus.cp0_epc_i         = epc;
    endtask

    // Reference model: the exception timeline is tracked as the absolute cycle
    // in which the flush pulse is due; everything up to it ignores inputs.
    int          m_cyc, m_flush_cyc, m_wd;
    logic        m_to;
    logic [31:0] m_cnt, m_newpc;
    logic [5:0]  e_stall;
    logic        e_flush, e_run, e_accept;

    function automatic void model_reset();
        m_cyc = 0; m_flush_cyc = -10; m_wd = 0;
        m_to = 1'b0; m_cnt = 32'h0; m_newpc = 32'h0;
    endfunction

    function automatic void model_predict(input logic [3:0] req, input logic [31:0] exc);
        int n;
        e_accept = 1'b0;
        e_flush  = 1'b0;
        e_run    = 1'b0;
        if (m_cyc == m_flush_cyc) begin
            e_stall = 6'd0;
            e_flush = 1'b1;
        end else if (m_cyc < m_flush_cyc) begin
            e_stall = 6'h3F;
        end else begin
            e_run = 1'b1;
            if (exc != 32'h0) begin
                e_stall  = 6'h3F;
                e_accept = 1'b1;
            end else begin
                n = req[3] ? 5 : req[2] ? 4 : req[1] ? 3 : req[0] ? 2 : 0;
                e_stall = 6'((1 << n) - 1);
            end
        end
    endfunction

    function automatic void model_commit(input logic [31:0] exc, input logic [31:0] epc);
        if (e_accept) begin
            m_newpc     = (exc == ERET) ? epc : EXC_VEC;
            m_flush_cyc = m_cyc + 2;
        end
        m_cnt = m_cnt + 32'(e_stall[0]);
        if (e_stall == 6'd0) m_wd = 0;
        else if (e_run && m_wd < TO) begin
            m_wd++;
            if (m_wd == TO) m_to = 1'b1;
        end
        m_cyc++;
    endfunction

    task automatic cycle(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc);
        @(negedge clk);
        drive(req, exc, epc);
        model_predict(req, exc);
        #1;
        check("stall",   32'(bus.stall),           32'(e_stall));
        check("flush",   32'(bus.flush),           32'(e_flush));
        check("new_pc",  bus.new_pc,               m_newpc);
        check("timeout", 32'(bus.stall_timeout_o), 32'(m_to));
        check("cnt",     bus.stall_cnt_o,          m_cnt);
        @(posedge clk);
        model_commit(exc, epc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(4'b1111, 32'h0, 32'h0);
        #1;
        check("rst_stall",   32'(bus.stall),           32'h0);
        check("rst_flush",   32'(bus.flush),           32'h0);
        check("rst_new_pc",  bus.new_pc,               32'h0);
        check("rst_timeout", 32'(bus.stall_timeout_o), 32'h0);
        check("rst_cnt",     bus.stall_cnt_o,          32'h0);
        drive(4'b0000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [3:0]  req;    // {mem, ex, id, if}
        logic [31:0] exc;
        logic [31:0] epc;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] newpc;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [3:0]  r_req;
        logic [31:0] r_exc, r_epc;

        drive(4'b0000, 32'h0, 32'h0);

        tbl[0]  = '{4'b0000, 32'h0, 32'h0,          6'b000000, 1'b0, 32'h0,          32'd0};
        tbl[1]  = '{4'b0010, 32'h0, 32'h0,          6'b000111, 1'b0, 32'h0,          32'd0};
        tbl[2]  = '{4'b1111, 32'h0, 32'h0,          6'b011111, 1'b0, 32'h0,          32'd1};
        tbl[3]  = '{4'b0001, 32'h0, 32'h0,          6'b000011, 1'b0, 32'h0,          32'd2};
        tbl[4]  = '{4'b0100, 32'h0, 32'h0,          6'b001111, 1'b0, 32'h0,          32'd3};
        tbl[5]  = '{4'b1000, 32'h0, 32'h0,          6'b011111, 1'b0, 32'h0,          32'd4};
        tbl[6]  = '{4'b1111, 32'h8, 32'h0,          6'b111111, 1'b0, 32'h0,          32'd5};
        tbl[7]  = '{4'b0000, 32'h0, 32'h0,          6'b111111, 1'b0, 32'h0000_0020, 32'd6};
        tbl[8]  = '{4'b1111, 32'h0, 32'h0,          6'b000000, 1'b1, 32'h0000_0020, 32'd7};
        tbl[9]  = '{4'b0000, 32'h0, 32'h0,          6'b000000, 1'b0, 32'h0000_0020, 32'd7};
        tbl[10] = '{4'b0000, ERET,  32'hBFC0_0100,  6'b111111, 1'b0, 32'h0000_0020, 32'd7};
        tbl[11] = '{4'b0000, 32'h8, 32'h1234_5678,  6'b111111, 1'b0, 32'hBFC0_0100, 32'd8};
        tbl[12] = '{4'b1000, 32'h8, 32'h1234_5678,  6'b000000, 1'b1, 32'hBFC0_0100, 32'd9};
        tbl[13] = '{4'b0000, 32'h0, 32'h0,          6'b000000, 1'b0, 32'hBFC0_0100, 32'd9};

        // Directed vector table
        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i].req, tbl[i].exc, tbl[i].epc);
            #1;
            check($sformatf("tbl%0d_stall", i),  32'(bus.stall), 32'(tbl[i].stall));
            check($sformatf("tbl%0d_flush", i),  32'(bus.flush), 32'(tbl[i].flush));
            check($sformatf("tbl%0d_new_pc", i), bus.new_pc,     tbl[i].newpc);
            check($sformatf("tbl%0d_cnt", i),    bus.stall_cnt_o, tbl[i].cnt);
        end

        // Reset in the middle of FLUSH drops the flush pulse at once
        do_reset();
        cycle(4'b0000, 32'h8, 32'h0);
        cycle(4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        drive(4'b1000, 32'h0, 32'h0);
        #1;
        check("midflush_flush_before", 32'(bus.flush), 32'h1);
        rst = 1'b0;
        #1;
        check("midflush_flush_after", 32'(bus.flush), 32'h0);
        check("midflush_stall_in_rst", 32'(bus.stall), 32'h0);
        @(negedge clk);
        drive(4'b0000, 32'h0, 32'h0);
        rst = 1'b1;
        model_reset();
        cycle(4'b0000, 32'h0, 32'h0);
        cycle(4'b0000, 32'h0, 32'h0);

        // Watchdog fires on the 8th consecutive stalled edge and stays set
        do_reset();
        repeat (7) cycle(4'b0100, 32'h0, 32'h0);
        #1;
        check("wd_before_limit", 32'(bus.stall_timeout_o), 32'h0);
        cycle(4'b0100, 32'h0, 32'h0);
        #1;
        check("wd_at_limit", 32'(bus.stall_timeout_o), 32'h1);
        repeat (3) cycle(4'b0000, 32'h0, 32'h0);
        check("wd_sticky", 32'(bus.stall_timeout_o), 32'h1);
        check("wd_cnt",    bus.stall_cnt_o,          32'd8);

        // Stall counter wraps from all-ones to zero
        @(negedge clk);
        drive(4'b0100, 32'h0, 32'h0);
        force dut.stall_cnt_d = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.stall_cnt_d;
        check("cnt_preload", bus.stall_cnt_o, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("cnt_wrap", bus.stall_cnt_o, 32'h0);
        drive(4'b0000, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("cnt_idle_after_wrap", bus.stall_cnt_o, 32'h0);

        // Random stimulus against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 249) do_reset();
            r_req = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            r_exc = 32'h0;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0:       r_exc = 32'h8;
                    1:       r_exc = ERET;
                    default: r_exc = $urandom | 32'h1;
                endcase
            end
            r_epc = $urandom;
            cycle(r_req, r_exc, r_epc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
